stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

BCD stopwatch that consumes the single-cycle 10 Hz tick produced by the 50 MHz tick divider and counts elapsed time as MM:SS.t. It sits directly downstream of the divider and upstream of the seven-segment display driver. Start/stop, lap-freeze and clear commands arrive as single-cycle pulses from the button edge-detect stage.

## Interface
- MAX_MIN_TENS, default 5: maximum value of the minutes-tens digit; the full-scale count is (MAX_MIN_TENS)9:59.9.
- Clock  in  1  system clock, 50 MHz.
- Resetn  in  1  asynchronous, active-low reset.
- Tick  in  1  one-cycle pulse at 10 Hz from the divider.
- StartStop  in  1  one-cycle pulse that toggles running/paused.
- Lap  in  1  one-cycle pulse that toggles display freeze while running.
- Clear  in  1  one-cycle pulse that returns to zero and idle.
- Tenths  out  4  displayed tenths digit, 0–9.
- SecOnes  out  4  displayed seconds-ones digit, 0–9.
- SecTens  out  4  displayed seconds-tens digit, 0–5.
- MinOnes  out  4  displayed minutes-ones digit, 0–9.
- MinTens  out  4  displayed minutes-tens digit, 0–MAX_MIN_TENS.
- Running  out  1  high in RUN and LAP.
- Frozen  out  1  high in LAP.
- Overflow  out  1  sticky full-scale flag.

## Operation
- The live counter is a chain of five BCD digits. On a counted Tick, tenths increments. Each digit carries into the next when it wraps at 9 (or 5 for SecTens).
- States:
  - IDLE: entered at reset or on Clear.
  - RUN: counting, display shows the live count.
  - LAP: counting, display frozen.
  - PAUSED: not counting, display shows the live count.
- Transitions:
  - IDLE --StartStop--> RUN.
  - RUN --StartStop--> PAUSED.
  - RUN --Lap--> LAP. Snapshot the live count into the display register.
  - LAP --Lap--> RUN. Display returns to live.
  - LAP --StartStop--> PAUSED. Display returns to live.
  - PAUSED --StartStop--> RUN.
  - Lap is ignored in IDLE and PAUSED.
  - Any state --Clear--> IDLE. Live count, snapshot and Overflow go to 0.
- Command priority in the same cycle: Clear > StartStop > Lap. The lower-priority command is discarded.
- Tick counting is based on the state held before the edge:
  - A Tick is counted only if the current state is RUN or LAP.
  - A Tick coincident with a StartStop that pauses is still counted.
  - A Tick coincident with a StartStop that starts is not counted.
  - A Tick coincident with Clear is discarded.
- Full scale: a counted Tick at (MAX_MIN_TENS)9:59.9 does not wrap. The count holds at full scale, Overflow is set, and the state goes to PAUSED. Overflow is cleared only by Clear or reset. StartStop in PAUSED with Overflow set is ignored.
- Digit outputs show the snapshot in LAP and the live count otherwise.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational input-to-output paths.
- On Resetn low, immediately and asynchronously:
  - state = IDLE;
  - all digits = 0;
  - Running = 0, Frozen = 0, Overflow = 0.
- Latency:
  - A counted Tick at edge N shows on the digit outputs after edge N (one cycle).
  - Commands take effect on state and flags after the same edge.
- A Tick held high for k cycles counts k times. The divider guarantees one cycle; the block does not re-edge-detect.
- Reset asserted mid-count returns to IDLE/zero. After release, the block waits in IDLE for StartStop.

## Structure
- The shared package holds:
  - the state enum (IDLE, RUN, LAP, PAUSED), 2 bits;
  - BCD digit width = 4;
  - the SecTens wrap limit = 5.
- Sub-module bcd_digit_counter:
  - parameter LIMIT;
  - ports Clock, Resetn, Clr, Inc, Digit[3:0], CarryOut.
  - CarryOut = Inc && Digit == LIMIT (combinational), so the carry ripples to the next digit in the same cycle.
  - It is instantiated five times.
- The top level holds the FSM, the snapshot register, the full-scale detect and the output mux.

## Test plan
- Reset then StartStop, followed by 125 Ticks → display 00:12.5, Running=1, Frozen=0.
- At 00:09.9 and 00:59.9, one Tick → 00:10.0 and 01:00.0 respectively, with the carry rippling across all affected digits in one cycle.
- At 00:03.0 in RUN, Lap, then 20 Ticks → display stays 00:03.0 with Frozen=1. A second Lap → display 00:05.0, Frozen=0.
- Tick and StartStop in the same cycle from RUN at 00:00.4 → 00:00.5 and PAUSED. The same from PAUSED → count unchanged and RUN.
- Preload to 59:59.8 by ticking, then 2 Ticks → 59:59.9, then Overflow=1, Running=0 and the display holds. StartStop is ignored. Clear → 00:00.0 with Overflow=0.
- Clear, StartStop and Tick in the same cycle while in RUN → IDLE and all zeros. Resetn pulsed low mid-count without a Clock edge → outputs zero immediately.

Source files
------------

// File: rtl/stopwatch_bcd_pkg.sv
// ============================================================================
// Module   : stopwatch_bcd_pkg
// Brief    : Shared types and constants for the MM:SS.t BCD stopwatch.
// Revision : 1.0
// ============================================================================
`default_nettype none

package stopwatch_bcd_pkg;

    localparam int                  DIGIT_W        = 4;
    localparam logic [DIGIT_W-1:0]  DEC_LIMIT      = 4'd9;
    localparam logic [DIGIT_W-1:0]  SEC_TENS_LIMIT = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LAP    = 2'd2,
        ST_PAUSED = 2'd3
    } sw_state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_tens;
        logic [DIGIT_W-1:0] min_ones;
        logic [DIGIT_W-1:0] sec_tens;
        logic [DIGIT_W-1:0] sec_ones;
        logic [DIGIT_W-1:0] tenths;
    } bcd_time_t;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_counter.sv
// ============================================================================
// Module   : bcd_digit_counter
// Brief    : One BCD digit that wraps at LIMIT and emits a same-cycle carry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_digit_counter
    import stopwatch_bcd_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] LIMIT = DEC_LIMIT
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Clr,
    input  logic               Inc,
    output logic [DIGIT_W-1:0] Digit,
    output logic               CarryOut
);

    logic [DIGIT_W-1:0] r_digit;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_digit <= '0;
        end else if (Clr) begin
            r_digit <= '0;
        end else if (Inc) begin
            r_digit <= (r_digit == LIMIT) ? '0 : r_digit + 4'd1;
        end
    end

    // Combinational so a whole run of wrapping digits advances on one edge.
    assign CarryOut = Inc && (r_digit == LIMIT);
    assign Digit    = r_digit;

endmodule

`default_nettype wire

// File: rtl/stopwatch_bcd.sv
// ============================================================================
// Module   : stopwatch_bcd
// Brief    : MM:SS.t stopwatch with run/pause, lap freeze, clear and sticky
//            full-scale overflow, counting 10 Hz ticks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stopwatch_bcd
    import stopwatch_bcd_pkg::*;
#(
    parameter int MAX_MIN_TENS = 5
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Tick,
    input  logic               StartStop,
    input  logic               Lap,
    input  logic               Clear,
    output logic [DIGIT_W-1:0] Tenths,
    output logic [DIGIT_W-1:0] SecOnes,
    output logic [DIGIT_W-1:0] SecTens,
    output logic [DIGIT_W-1:0] MinOnes,
    output logic [DIGIT_W-1:0] MinTens,
    output logic               Running,
    output logic               Frozen,
    output logic               Overflow
);

    localparam logic [DIGIT_W-1:0] MIN_TENS_LIMIT = 4'(MAX_MIN_TENS);

    sw_state_t  r_state;
    bcd_time_t  r_snap;
    logic       r_ovf;
    logic       r_running;
    logic       r_frozen;

    bcd_time_t  w_live;
    bcd_time_t  w_disp;
    logic [4:0] w_carry;
    logic       w_counting;
    logic       w_count_tick;
    logic       w_full;
    logic       w_inc;
    logic       w_ovf_hit;
    logic       w_unused_carry;

    // Counting is judged on the state held before the edge; Clear drops the tick.
    assign w_counting   = (r_state == ST_RUN) || (r_state == ST_LAP);
    assign w_count_tick = Tick && w_counting && !Clear;

    assign w_full = (w_live.min_tens == MIN_TENS_LIMIT) &&
                    (w_live.min_ones == DEC_LIMIT)      &&
                    (w_live.sec_tens == SEC_TENS_LIMIT) &&
                    (w_live.sec_ones == DEC_LIMIT)      &&
                    (w_live.tenths   == DEC_LIMIT);

    assign w_inc          = w_count_tick && !w_full;
    assign w_ovf_hit      = w_count_tick && w_full;
    assign w_unused_carry = w_carry[4];

    bcd_digit_counter #(.LIMIT(DEC_LIMIT)) u_tenths (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Clr      (Clear),
        .Inc      (w_inc),
        .Digit    (w_live.tenths),
        .CarryOut (w_carry[0])
    );

    bcd_digit_counter #(.LIMIT(DEC_LIMIT)) u_sec_ones (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Clr      (Clear),
        .Inc      (w_carry[0]),
        .Digit    (w_live.sec_ones),
        .CarryOut (w_carry[1])
    );

    bcd_digit_counter #(.LIMIT(SEC_TENS_LIMIT)) u_sec_tens (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Clr      (Clear),
        .Inc      (w_carry[1]),
        .Digit    (w_live.sec_tens),
        .CarryOut (w_carry[2])
    );

    bcd_digit_counter #(.LIMIT(DEC_LIMIT)) u_min_ones (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Clr      (Clear),
        .Inc      (w_carry[2]),
        .Digit    (w_live.min_ones),
        .CarryOut (w_carry[3])
    );

    // Full-scale gating keeps this carry low; it is never consumed.
    bcd_digit_counter #(.LIMIT(MIN_TENS_LIMIT)) u_min_tens (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Clr      (Clear),
        .Inc      (w_carry[3]),
        .Digit    (w_live.min_tens),
        .CarryOut (w_carry[4])
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= ST_IDLE;
            r_snap    <= '0;
            r_ovf     <= 1'b0;
            r_running <= 1'b0;
            r_frozen  <= 1'b0;
        end else if (Clear) begin
            r_state   <= ST_IDLE;
            r_snap    <= '0;
            r_ovf     <= 1'b0;
            r_running <= 1'b0;
            r_frozen  <= 1'b0;
        end else if (w_ovf_hit) begin
            r_state   <= ST_PAUSED;
            r_ovf     <= 1'b1;
            r_running <= 1'b0;
            r_frozen  <= 1'b0;
        end else if (StartStop) begin
            case (r_state)
                ST_IDLE: begin
                    r_state   <= ST_RUN;
                    r_running <= 1'b1;
                end
                ST_RUN, ST_LAP: begin
                    r_state   <= ST_PAUSED;
                    r_running <= 1'b0;
                    r_frozen  <= 1'b0;
                end
                ST_PAUSED: begin
                    if (!r_ovf) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end else if (Lap) begin
            case (r_state)
                ST_RUN: begin
                    r_state  <= ST_LAP;
                    r_frozen <= 1'b1;
                    r_snap   <= w_live;
                end
                ST_LAP: begin
                    r_state  <= ST_RUN;
                    r_frozen <= 1'b0;
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign w_disp   = (r_state == ST_LAP) ? r_snap : w_live;

    assign Tenths   = w_disp.tenths;
    assign SecOnes  = w_disp.sec_ones;
    assign SecTens  = w_disp.sec_tens;
    assign MinOnes  = w_disp.min_ones;
    assign MinTens  = w_disp.min_tens;
    assign Running  = r_running;
    assign Frozen   = r_frozen;
    assign Overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_bcd.sv
// ============================================================================
// Module   : tb_stopwatch_bcd
// Brief    : Scoreboard bench for stopwatch_bcd against an integer-tenths model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_bcd;

    localparam int MAXMT  = 5;
    localparam int FULL   = (MAXMT * 10 + 9) * 600 + 599;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_LAP  = 2;
    localparam int S_PAUS = 3;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Tick, StartStop, Lap, Clear;
    logic [3:0] Tenths, SecOnes, SecTens, MinOnes, MinTens;
    logic       Running, Frozen, Overflow;

    int          n_total = 0;
    int          n_bad   = 0;
    int          m_state = S_IDLE;
    int          m_cnt   = 0;
    int          m_snap  = 0;
    bit          m_ovf   = 1'b0;
    logic [22:0] sb[$];
    logic [22:0] exp_w;

    stopwatch_bcd #(.MAX_MIN_TENS(MAXMT)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Tick      (Tick),
        .StartStop (StartStop),
        .Lap       (Lap),
        .Clear     (Clear),
        .Tenths    (Tenths),
        .SecOnes   (SecOnes),
        .SecTens   (SecTens),
        .MinOnes   (MinOnes),
        .MinTens   (MinTens),
        .Running   (Running),
        .Frozen    (Frozen),
        .Overflow  (Overflow)
    );

    always #5 Clock = ~Clock;

    function automatic logic [22:0] model_word();
        int d;
        logic [19:0] dg;
        d  = (m_state == S_LAP) ? m_snap : m_cnt;
        dg = {4'(d / 6000), 4'((d / 600) % 10), 4'((d / 100) % 6),
              4'((d / 10) % 10), 4'(d % 10)};
        return {dg, (m_state == S_RUN) || (m_state == S_LAP),
                (m_state == S_LAP), m_ovf};
    endfunction

    function automatic logic [22:0] act_word();
        return {MinTens, MinOnes, SecTens, SecOnes, Tenths, Running, Frozen, Overflow};
    endfunction

    // Drives one cycle of commands, advances the model, queues the expectation.
    task automatic step(input bit t, input bit ss, input bit lp, input bit cl);
        int pre;
        bit counting;
        bit hit;
        @(negedge Clock);
        Tick = t; StartStop = ss; Lap = lp; Clear = cl;
        pre      = m_cnt;
        counting = (m_state == S_RUN) || (m_state == S_LAP);
        hit      = 1'b0;
        if (cl) begin
            m_state = S_IDLE; m_cnt = 0; m_snap = 0; m_ovf = 1'b0;
        end else begin
            if (t && counting) begin
                if (m_cnt == FULL) begin
                    m_ovf = 1'b1;
                    hit   = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (hit) begin
                m_state = S_PAUS;
            end else if (ss) begin
                if (m_state == S_IDLE)                          m_state = S_RUN;
                else if (m_state == S_RUN || m_state == S_LAP)  m_state = S_PAUS;
                else if (!m_ovf)                                m_state = S_RUN;
            end else if (lp) begin
                if (m_state == S_RUN) begin
                    m_state = S_LAP;
                    m_snap  = pre;
                end else if (m_state == S_LAP) begin
                    m_state = S_RUN;
                end
            end
        end
        sb.push_back(model_word());
        @(posedge Clock);
        #1;
        Tick = 1'b0; StartStop = 1'b0; Lap = 1'b0; Clear = 1'b0;
    endtask

    task automatic test_reset();
        m_state = S_IDLE; m_cnt = 0; m_snap = 0; m_ovf = 1'b0;
        #1;
        n_total++;
        if (act_word() !== 23'd0) begin
            n_bad++; $display("FAIL reset_hold: got %h exp %h", act_word(), 23'd0);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        exp_w = sb.pop_front(); n_total++;
        if (act_word() !== exp_w) begin
            n_bad++; $display("FAIL idle_ignores: got %h exp %h", act_word(), exp_w);
        end
    endtask

    task automatic test_count();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        exp_w = sb.pop_front(); n_total++;
        if (act_word() !== exp_w) begin
            n_bad++; $display("FAIL start: got %h exp %h", act_word(), exp_w);
        end
        for (int i = 0; i < 125; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            exp_w = sb.pop_front(); n_total++;
            if (act_word() !== exp_w) begin
                n_bad++; $display("FAIL count_tick%0d: got %h exp %h", i, act_word(), exp_w);
            end
        end
        n_total++;
        if (act_word() !== {4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 3'b100}) begin
            n_bad++; $display("FAIL count_125: got %h exp 00:12.5 running", act_word());
        end
    endtask

    task automatic test_carry();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        sb.delete();
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            exp_w = sb.pop_front(); n_total++;
            if (act_word() !== exp_w) begin
                n_bad++;
                if (n_bad < 40) $display("FAIL carry_tick%0d: got %h exp %h", i, act_word(), exp_w);
            end
            if (i == 99) begin
                n_total++;
                if (act_word() !== {4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 3'b100}) begin
                    n_bad++; $display("FAIL carry_10s: got %h exp 00:10.0", act_word());
                end
            end
        end
        n_total++;
        if (act_word() !== {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 3'b100}) begin
            n_bad++; $display("FAIL carry_1min: got %h exp 01:00.0", act_word());
        end
    endtask

    task automatic test_lap();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        sb.delete();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            exp_w = sb.pop_front(); n_total++;
            if (act_word() !== exp_w) begin
                n_bad++;
                if (n_bad < 40) $display("FAIL lap_tick%0d: got %h exp %h", i, act_word(), exp_w);
            end
        end
        sb.delete();
        n_total++;
        if (act_word() !== {4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 3'b110}) begin
            n_bad++; $display("FAIL lap_frozen: got %h exp 00:03.0 frozen", act_word());
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        exp_w = sb.pop_front(); n_total++;
        if (act_word() !== {4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 3'b100} || act_word() !== exp_w) begin
            n_bad++; $display("FAIL lap_release: got %h exp %h", act_word(), exp_w);
        end
    endtask

    task automatic test_tick_startstop();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        sb.delete();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        exp_w = sb.pop_front(); n_total++;
        if (act_word() !== {4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 3'b000} || act_word() !== exp_w) begin
            n_bad++; $display("FAIL tick_pause: got %h exp %h", act_word(), exp_w);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        exp_w = sb.pop_front(); n_total++;
        if (act_word() !== exp_w) begin
            n_bad++; $display("FAIL paused_lap_ignored: got %h exp %h", act_word(), exp_w);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        exp_w = sb.pop_front(); n_total++;
        if (act_word() !== {4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 3'b100} || act_word() !== exp_w) begin
            n_bad++; $display("FAIL tick_resume: got %h exp %h", act_word(), exp_w);
        end
    endtask

    task automatic test_overflow();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        sb.delete();
        for (int i = 0; i < FULL - 1; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            exp_w = sb.pop_front(); n_total++;
            if (act_word() !== exp_w) begin
                n_bad++;
                if (n_bad < 40) $display("FAIL preload_tick%0d: got %h exp %h", i, act_word(), exp_w);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        exp_w = sb.pop_front(); n_total++;
        if (act_word() !== {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 3'b100} || act_word() !== exp_w) begin
            n_bad++; $display("FAIL full_scale: got %h exp %h", act_word(), exp_w);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        exp_w = sb.pop_front(); n_total++;
        if (act_word() !== {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 3'b001} || act_word() !== exp_w) begin
            n_bad++; $display("FAIL overflow_set: got %h exp %h", act_word(), exp_w);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        sb.pop_front();
        exp_w = sb.pop_front(); n_total++;
        if (act_word() !== {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 3'b001} || act_word() !== exp_w) begin
            n_bad++; $display("FAIL overflow_startstop_ignored: got %h exp %h", act_word(), exp_w);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        exp_w = sb.pop_front(); n_total++;
        if (act_word() !== 23'd0 || act_word() !== exp_w) begin
            n_bad++; $display("FAIL overflow_clear: got %h exp %h", act_word(), exp_w);
        end
    endtask

    task automatic test_clear_priority();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        sb.delete();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        exp_w = sb.pop_front(); n_total++;
        if (act_word() !== 23'd0 || act_word() !== exp_w) begin
            n_bad++; $display("FAIL clear_priority: got %h exp %h", act_word(), exp_w);
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        sb.delete();
        n_total++;
        if (act_word() !== {4'd0, 4'd0, 4'd0, 4'd1, 4'd3, 3'b100}) begin
            n_bad++; $display("FAIL pre_reset_count: got %h exp 00:01.3 running", act_word());
        end
        Resetn = 1'b0;
        m_state = S_IDLE; m_cnt = 0; m_snap = 0; m_ovf = 1'b0;
        #1;
        n_total++;
        if (act_word() !== 23'd0) begin
            n_bad++; $display("FAIL async_reset: got %h exp %h", act_word(), 23'd0);
        end
        #1;
        Resetn = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        exp_w = sb.pop_front(); n_total++;
        if (act_word() !== exp_w) begin
            n_bad++; $display("FAIL post_reset_idle: got %h exp %h", act_word(), exp_w);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        sb.pop_front();
        exp_w = sb.pop_front(); n_total++;
        if (act_word() !== {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 3'b100} || act_word() !== exp_w) begin
            n_bad++; $display("FAIL post_reset_start: got %h exp %h", act_word(), exp_w);
        end
    endtask

    initial begin
        Resetn = 1'b0;
        Tick = 1'b0; StartStop = 1'b0; Lap = 1'b0; Clear = 1'b0;
        repeat (2) @(posedge Clock);
        test_reset();
        test_count();
        test_carry();
        test_lap();
        test_tick_startstop();
        test_overflow();
        test_clear_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
